// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// In-order issue controller sitting between decode and execute. Every cycle it
// decides whether the instruction presented by decode may issue, based on:
//   - a pending-write bitmap (busy) that blocks RAW and WAW hazards,
//   - a result shift register (RSR) that reserves the single register-file
//     write port, one slot per future cycle, so at most one unit writes back
//     per cycle,
//   - a kill window that flushes younger instructions after a taken branch.
//
// Handshake: decode holds id_* stable and keeps id_valid high until it sees
// issue = 1 in the same cycle. stall = 1 means "hold decode and fetch, present
// the same instruction again next cycle". kill = 1 means "the instruction in
// decode is flushed"; it neither issues nor stalls. The scheduler keeps no
// state for stalled or killed instructions.
//
// Parameters:
//   MAX_LAT      largest writeback latency in cycles (1..4); RSR depth
//   KILL_CYCLES  cycles kill stays high after a taken branch (1..3)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid                  decode presents an instruction
//   id_rs1, id_rs2            source register indices
//   id_rs1_used, id_rs2_used  source actually read
//   id_rd, id_rd_we           destination index and write enable
//   id_lat                    writeback latency minus one
//   btaken                    branch resolved taken in EX this cycle
//   issue, stall, kill        same-cycle issue decision (combinational)
//   wb_valid, wb_rd           register-file write scheduled this cycle (registered)
//   busy                      pending-write bitmap, bit 0 always 0
// -----------------------------------------------------------------------------
module issue_scheduler #(
  parameter int MAX_LAT     = 4,
  parameter int KILL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_we,
  input  logic [1:0]  id_lat,
  input  logic        btaken,
  output logic        issue,
  output logic        stall,
  output logic        kill,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] busy
);

  localparam logic [1:0] KILL_RELOAD = 2'(KILL_CYCLES - 1);

  // RSR: entry i holds the write that reaches the register file i cycles
  // from now; entry 0 is the write happening this cycle.
  logic [MAX_LAT-1:0] rsr_v;
  logic [4:0]         rsr_rd [MAX_LAT];

  logic [31:0] busy_q;
  logic [31:0] busy_next;
  logic [1:0]  kcnt;

  logic we_eff;
  logic raw_hz;
  logic waw_hz;
  logic struct_hz;
  logic hazard;
  logic kill_win;
  logic do_alloc;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    we_eff = id_rd_we && (id_rd != 5'd0);

    raw_hz = (id_rs1_used && (id_rs1 != 5'd0) && busy_q[id_rs1]) ||
             (id_rs2_used && (id_rs2 != 5'd0) && busy_q[id_rs2]);

    waw_hz = we_eff && busy_q[id_rd];

    // The entry in slot id_lat+1 moves into slot id_lat at this edge, so a
    // new write with latency id_lat would land on the same writeback cycle.
    // When id_lat+1 reaches MAX_LAT there is no such entry and no conflict.
    struct_hz = 1'b0;
    for (int i = 1; i < MAX_LAT; i++) begin
      if (rsr_v[i] && (i == int'(id_lat) + 1)) begin
        struct_hz = 1'b1;
      end
    end
    struct_hz = struct_hz && we_eff;

    hazard = raw_hz || waw_hz || struct_hz;
  end

  // ---------------------------------------------------------------------------
  // Issue decision; kill dominates stall, and reset silences all three.
  // ---------------------------------------------------------------------------
  always_comb begin
    kill_win = btaken || (kcnt != 2'd0);
    kill     = !rst && kill_win;
    stall    = !rst && id_valid && !kill_win && hazard;
    issue    = !rst && id_valid && !kill_win && !hazard;
    do_alloc = issue && we_eff;
  end

  // ---------------------------------------------------------------------------
  // Next busy bitmap. The retiring write (RSR[0]) and a new allocation can
  // never name the same register because WAW blocks the allocation.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_next = busy_q;
    if (rsr_v[0]) begin
      busy_next[rsr_rd[0]] = 1'b0;
    end
    if (do_alloc) begin
      busy_next[id_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsr_v  <= '0;
      for (int i = 0; i < MAX_LAT; i++) begin
        rsr_rd[i] <= 5'd0;
      end
      busy_q <= '0;
      kcnt   <= 2'd0;
    end else begin
      // Shift toward slot 0; the top slot empties.
      for (int i = 0; i < MAX_LAT - 1; i++) begin
        rsr_v[i]  <= rsr_v[i+1];
        rsr_rd[i] <= rsr_rd[i+1];
      end
      rsr_v[MAX_LAT-1]  <= 1'b0;
      rsr_rd[MAX_LAT-1] <= 5'd0;

      // Allocation lands in slot id_lat after the shift (later NBA wins).
      if (do_alloc) begin
        for (int i = 0; i < MAX_LAT; i++) begin
          if (i == int'(id_lat)) begin
            rsr_v[i]  <= 1'b1;
            rsr_rd[i] <= id_rd;
          end
        end
      end

      busy_q <= busy_next;

      // A new taken branch restarts the window even if one is active.
      if (btaken) begin
        kcnt <= KILL_RELOAD;
      end else if (kcnt != 2'd0) begin
        kcnt <= kcnt - 2'd1;
      end
    end
  end

  assign wb_valid = rsr_v[0];
  assign wb_rd    = rsr_rd[0];
  assign busy     = busy_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
//
// Driver presents one decode slot per cycle and evaluates a reference model
// that tracks pending writes as (rd, writeback cycle) pairs and the last taken
// branch cycle. Each cycle's expected outputs are pushed to exp_q; a monitor
// on the falling edge pops them and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;

  localparam int MAX_LAT     = 4;
  localparam int KILL_CYCLES = 2;
  localparam int W           = 73; // {cyc[31:0], issue, stall, kill, wbv, wbrd[4:0], busy[31:0]}

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_rd_we;
  logic [1:0]  id_lat;
  logic        btaken;
  logic        issue, stall, kill, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy;

  always #5 clk = ~clk;

  issue_scheduler #(.MAX_LAT(MAX_LAT), .KILL_CYCLES(KILL_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_lat(id_lat),
    .btaken(btaken),
    .issue(issue), .stall(stall), .kill(kill),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .busy(busy)
  );

  // Illegal latency is a protocol violation by the driver.
  always @(posedge clk) begin
    if (!rst && id_valid) begin
      assert (int'(id_lat) < MAX_LAT)
        else $error("protocol violation: id_lat %0d with MAX_LAT %0d", id_lat, MAX_LAT);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_cyc   = 0;
  int last_bt = -100;
  int pend_rd[$];
  int pend_wb[$];

  task automatic check(input string name, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver + reference model: one call = one clock cycle.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic [1:0] lat, input logic bt,
                       input logic r, output logic iss, output logic kl);
    logic [31:0] busy_e;
    logic        wbv_e, slot_taken, we_e, hz, kill_e, stall_e, issue_e;
    logic [4:0]  wbrd_e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2;
    id_rs2_used = u2; id_rd = rd; id_rd_we = we; id_lat = lat; btaken = bt;

    // Forget writes that have already happened.
    for (int i = pend_wb.size() - 1; i >= 0; i--) begin
      if (pend_wb[i] < m_cyc) begin
        pend_wb.delete(i);
        pend_rd.delete(i);
      end
    end
    busy_e = '0; wbv_e = 1'b0; wbrd_e = 5'd0; slot_taken = 1'b0;
    foreach (pend_wb[i]) begin
      busy_e[pend_rd[i]] = 1'b1;
      if (pend_wb[i] == m_cyc) begin
        wbv_e  = 1'b1;
        wbrd_e = 5'(pend_rd[i]);
      end
      // The write port is already claimed for the cycle this one would use.
      if (pend_wb[i] == m_cyc + int'(lat) + 1) slot_taken = 1'b1;
    end
    we_e = we && (rd != 5'd0);
    hz = (u1 && rs1 != 0 && busy_e[rs1]) || (u2 && rs2 != 0 && busy_e[rs2]) ||
         (we_e && busy_e[rd]) || (we_e && slot_taken);
    kill_e  = !r && (bt || (m_cyc - last_bt) < KILL_CYCLES);
    stall_e = !r && v && !kill_e && hz;
    issue_e = !r && v && !kill_e && !hz;

    exp_q.push_back({32'(m_cyc), issue_e, stall_e, kill_e, wbv_e, wbrd_e, busy_e});

    if (r) begin
      pend_rd.delete();
      pend_wb.delete();
      last_bt = -100;
    end else begin
      if (bt) last_bt = m_cyc;
      if (issue_e && we_e) begin
        pend_rd.push_back(int'(rd));
        pend_wb.push_back(m_cyc + int'(lat) + 1);
      end
    end
    m_cyc++;
    iss = issue_e;
    kl  = kill_e;
  endtask

  task automatic nops(input int n);
    logic i, k;
    for (int j = 0; j < n; j++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i, k);
  endtask

  // Present one instruction until the model says it issued (bounded).
  task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we,
                         input logic [1:0] lat, input int max_cyc);
    logic iss, kl;
    iss = 1'b0;
    for (int n = 0; n < max_cyc && !iss; n++) begin
      drive(1, rs1, u1, rs2, u2, rd, we, lat, 0, 0, iss, kl);
    end
    n_checks++;
    if (iss) n_pass++;
    else $display("FAIL present_bound rd=%0d got=no_issue exp=issue within %0d", rd, max_cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    int c;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      c = int'(e[72:41]);
      check("issue",    c, 32'(issue),    32'(e[40]));
      check("stall",    c, 32'(stall),    32'(e[39]));
      check("kill",     c, 32'(kill),     32'(e[38]));
      check("wb_valid", c, 32'(wb_valid), 32'(e[37]));
      if (e[37]) check("wb_rd", c, 32'(wb_rd), 32'(e[36:32]));
      check("busy",     c, busy,          e[31:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic iss, kl;
    logic [4:0] c_rs1, c_rs2, c_rd;
    logic c_u1, c_u2, c_we, c_v, bt, r;
    logic [1:0] c_lat;

    rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0;
    id_rs2_used = 0; id_rd = 0; id_rd_we = 0; id_lat = 0; btaken = 0;
    repeat (2) @(posedge clk);

    // Reset state observed under reset, with a presented instruction and branch.
    drive(1, 0, 0, 0, 0, 5'd3, 1, 0, 1, 1, iss, kl);
    nops(1);

    // Independent stream
    drive(1, 0, 0, 0, 0, 5'd1, 1, 0, 0, 0, iss, kl);
    drive(1, 0, 0, 0, 0, 5'd2, 1, 0, 0, 0, iss, kl);
    drive(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, iss, kl);
    nops(4);

    // RAW on a 4-cycle result
    drive(1, 0, 0, 0, 0, 5'd5, 1, 3, 0, 0, iss, kl);
    present(5'd5, 1, 0, 0, 5'd13, 1, 0, 8);
    nops(4);

    // Structural conflict on the write port
    drive(1, 0, 0, 0, 0, 5'd6, 1, 2, 0, 0, iss, kl);
    present(0, 0, 0, 0, 5'd7, 1, 1, 8);
    nops(5);

    // WAW, then x0 writes
    drive(1, 0, 0, 0, 0, 5'd8, 1, 3, 0, 0, iss, kl);
    present(0, 0, 0, 0, 5'd8, 1, 0, 8);
    present(0, 0, 0, 0, 5'd0, 1, 0, 2);
    present(5'd0, 1, 5'd0, 1, 5'd0, 1, 3, 2);
    nops(5);

    // Kill during a pending stall, restarted by a second taken branch
    drive(1, 0, 0, 0, 0, 5'd9, 1, 3, 0, 0, iss, kl);
    drive(1, 5'd9, 1, 0, 0, 5'd14, 1, 0, 0, 0, iss, kl);
    drive(1, 5'd9, 1, 0, 0, 5'd14, 1, 0, 1, 0, iss, kl);
    drive(1, 5'd9, 1, 0, 0, 5'd14, 1, 0, 1, 0, iss, kl);
    drive(1, 5'd9, 1, 0, 0, 5'd14, 1, 0, 0, 0, iss, kl);
    present(5'd9, 1, 0, 0, 5'd14, 1, 0, 6);
    nops(5);

    // Reset with three writebacks in flight
    drive(1, 0, 0, 0, 0, 5'd10, 1, 3, 0, 0, iss, kl);
    drive(1, 0, 0, 0, 0, 5'd11, 1, 3, 0, 0, iss, kl);
    drive(1, 0, 0, 0, 0, 5'd12, 1, 3, 0, 0, iss, kl);
    drive(1, 0, 0, 0, 0, 5'd15, 1, 0, 0, 1, iss, kl);
    present(5'd10, 1, 0, 0, 5'd10, 1, 1, 1);
    nops(5);

    // Randomized traffic; a stalled instruction is re-presented unchanged.
    c_v = 0; c_rs1 = 0; c_rs2 = 0; c_u1 = 0; c_u2 = 0; c_rd = 0; c_we = 0; c_lat = 0;
    for (int n = 0; n < 3000; n++) begin
      bt = ($urandom_range(0, 99) < 5);
      r  = ($urandom_range(0, 299) == 0);
      drive(c_v, c_rs1, c_u1, c_rs2, c_u2, c_rd, c_we, c_lat, bt, r, iss, kl);
      if (!c_v || iss || kl || r) begin
        c_v   = ($urandom_range(0, 3) != 0);
        c_rs1 = 5'($urandom_range(0, 7));
        c_rs2 = 5'($urandom_range(0, 7));
        c_u1  = 1'($urandom_range(0, 1));
        c_u2  = 1'($urandom_range(0, 1));
        c_rd  = 5'($urandom_range(0, 7));
        c_we  = ($urandom_range(0, 4) != 0);
        c_lat = 2'($urandom_range(0, MAX_LAT - 1));
      end
    end
    nops(6);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain got=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
